hdpldadapt_sr_sm_mseg: RTL and testbench

Parametrised load/shift sequencer for the adapter serial-shift-register chain. It replaces the fixed PCS/HIP/parity/reserved chain-length selection with NUM_SEG independently enabled segments of programmable length. It also adds:
- an inter-frame gap;
- a one-shot mode;
- frame completion and counting;
- configuration-error detection.

It sits in the TX channel between the CSR-synchronised transfer enable and the SR chain's load/shift controls.

---
 rtl/hdpldadapt_sr_pkg.sv | 27 ++
 rtl/hdpldadapt_sr_len_sum.sv | 22 ++
 rtl/hdpldadapt_sr_sm_mseg.sv | 153 +++++++++++++++
 tb/tb_hdpldadapt_sr_sm_mseg.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hdpldadapt_sr_pkg.sv
// Shared definitions for the segmented serial-shift-register load/shift sequencer.
package hdpldadapt_sr_pkg;

  // Sequencer states; the encoding is exported on the testbus
  typedef enum logic [1:0] {
    SR_IDLE  = 2'b00,
    SR_LOAD  = 2'b01,
    SR_SHIFT = 2'b10,
    SR_GAP   = 2'b11
  } sr_state_e;

  // Default parameter values
  localparam int SR_NUM_SEG_DEF   = 4;
  localparam int SR_SEG_LEN_W_DEF = 7;
  localparam int SR_GAP_W_DEF     = 3;

  // Testbus layout: {2'b0, state, cfg_err, frame_done, shift_en, loadout, cnt[7:0]}
  function automatic logic [15:0] sr_pack_testbus(input sr_state_e  st,
                                                  input logic       cfg_err,
                                                  input logic       frame_done,
                                                  input logic       shift_en,
                                                  input logic       loadout,
                                                  input logic [7:0] cnt);
    return {2'b00, st, cfg_err, frame_done, shift_en, loadout, cnt};
  endfunction

endpackage

// File: rtl/hdpldadapt_sr_len_sum.sv
// Masked sum of the programmed segment lengths (total chain length).
module hdpldadapt_sr_len_sum #(
  parameter int NUM_SEG   = 4,
  parameter int SEG_LEN_W = 7,
  parameter int CNT_W     = 9
) (
  input  logic [NUM_SEG-1:0]           seg_en,
  input  logic [NUM_SEG*SEG_LEN_W-1:0] seg_len,
  output logic [CNT_W-1:0]             len_sum
);

  // Add the length of every enabled segment; CNT_W is wide enough that this cannot overflow
  always_comb begin
    len_sum = '0;
    for (int i = 0; i < NUM_SEG; i++) begin
      if (seg_en[i]) begin
        len_sum = len_sum + CNT_W'(seg_len[i*SEG_LEN_W +: SEG_LEN_W]);
      end
    end
  end

endmodule

// File: rtl/hdpldadapt_sr_sm_mseg.sv
// Load/shift sequencer for the adapter SR chain with programmable segments,
// inter-frame gap, one-shot mode, frame counting and zero-length detection.
module hdpldadapt_sr_sm_mseg
  import hdpldadapt_sr_pkg::*;
#(
  parameter int NUM_SEG   = SR_NUM_SEG_DEF,
  parameter int SEG_LEN_W = SR_SEG_LEN_W_DEF,
  parameter int GAP_W     = SR_GAP_W_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         transfer_en,
  input  logic [NUM_SEG-1:0]           r_seg_en,
  input  logic [NUM_SEG*SEG_LEN_W-1:0] r_seg_len,
  input  logic [GAP_W-1:0]             r_gap_cycles,
  input  logic                         r_oneshot,
  input  logic                         start,
  output logic                         sr_loadout,
  output logic                         sr_shift_en,
  output logic                         frame_done,
  output logic [7:0]                   frame_cnt,
  output logic                         busy,
  output logic                         cfg_err,
  output logic [15:0]                  sr_sm_testbus
);

  localparam int CNT_W = SEG_LEN_W + $clog2(NUM_SEG);

  sr_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] len_sum;
  logic [7:0]       frame_cnt_q, frame_cnt_d;
  logic             cfg_err_q, cfg_err_d;
  logic             frame_done_q, frame_done_d;
  logic             loadout_q, loadout_d;
  logic             shift_q, shift_d;
  logic             busy_q, busy_d;
  logic             req;
  logic             shift_last;
  logic             gap_last;

  hdpldadapt_sr_len_sum #(
    .NUM_SEG   (NUM_SEG),
    .SEG_LEN_W (SEG_LEN_W),
    .CNT_W     (CNT_W)
  ) u_len_sum (
    .seg_en  (r_seg_en),
    .seg_len (r_seg_len),
    .len_sum (len_sum)
  );

  // Request qualification and end-of-phase detection
  always_comb begin
    req        = transfer_en & (r_oneshot ? start : 1'b1);
    shift_last = (cnt_q == (len_q - CNT_W'(1)));
    gap_last   = ((cnt_q + CNT_W'(1)) >= CNT_W'(r_gap_cycles));
  end

  // Next state, counters and status; transfer_en low overrides every transition
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    len_d        = len_q;
    cfg_err_d    = cfg_err_q;
    frame_done_d = 1'b0;
    frame_cnt_d  = frame_cnt_q;
    if (!transfer_en) begin
      state_d = SR_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        SR_IDLE: begin
          cnt_d = '0;
          if (req) begin
            if (len_sum != '0) state_d = SR_LOAD;
            else               cfg_err_d = 1'b1;
          end
        end
        SR_LOAD: begin
          len_d   = len_sum;
          cnt_d   = '0;
          state_d = SR_SHIFT;
        end
        SR_SHIFT: begin
          if (shift_last) begin
            frame_done_d = 1'b1;
            frame_cnt_d  = frame_cnt_q + 8'd1;
            cnt_d        = '0;
            if (r_gap_cycles != '0) state_d = SR_GAP;
            else if (!r_oneshot)    state_d = SR_LOAD;
            else                    state_d = SR_IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        SR_GAP: begin
          if (gap_last) begin
            cnt_d   = '0;
            state_d = r_oneshot ? SR_IDLE : SR_LOAD;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = SR_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
    // A frame that actually starts clears any earlier zero-length error
    if (state_d == SR_LOAD) cfg_err_d = 1'b0;
    // Moore outputs decoded from the next state so they register with it
    loadout_d = (state_d == SR_IDLE) || (state_d == SR_LOAD);
    shift_d   = (state_d == SR_SHIFT);
    busy_d    = (state_d != SR_IDLE);
  end

  // State, counter and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= SR_IDLE;
      cnt_q        <= '0;
      len_q        <= '0;
      cfg_err_q    <= 1'b0;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= 8'd0;
      loadout_q    <= 1'b1;
      shift_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      len_q        <= len_d;
      cfg_err_q    <= cfg_err_d;
      frame_done_q <= frame_done_d;
      frame_cnt_q  <= frame_cnt_d;
      loadout_q    <= loadout_d;
      shift_q      <= shift_d;
      busy_q       <= busy_d;
    end
  end

  assign sr_loadout    = loadout_q;
  assign sr_shift_en   = shift_q;
  assign frame_done    = frame_done_q;
  assign frame_cnt     = frame_cnt_q;
  assign busy          = busy_q;
  assign cfg_err       = cfg_err_q;
  assign sr_sm_testbus = sr_pack_testbus(state_q, cfg_err_q, frame_done_q, shift_q, loadout_q,
                                         8'(cnt_q));

endmodule

// File: tb/tb_hdpldadapt_sr_sm_mseg.sv
// Self-checking bench for hdpldadapt_sr_sm_mseg: directed scenarios plus randomised
// continuous-mode configurations against a frame-period reference model.
module tb_hdpldadapt_sr_sm_mseg;

  localparam int NUM_SEG   = 4;
  localparam int SEG_LEN_W = 7;
  localparam int GAP_W     = 3;

  logic                         clk = 1'b0;
  logic                         rst;
  logic                         transfer_en;
  logic [NUM_SEG-1:0]           r_seg_en;
  logic [NUM_SEG*SEG_LEN_W-1:0] r_seg_len;
  logic [GAP_W-1:0]             r_gap_cycles;
  logic                         r_oneshot;
  logic                         start;
  logic                         sr_loadout;
  logic                         sr_shift_en;
  logic                         frame_done;
  logic [7:0]                   frame_cnt;
  logic                         busy;
  logic                         cfg_err;
  logic [15:0]                  sr_sm_testbus;
  logic [28:0]                  obs;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  hdpldadapt_sr_sm_mseg #(
    .NUM_SEG   (NUM_SEG),
    .SEG_LEN_W (SEG_LEN_W),
    .GAP_W     (GAP_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .transfer_en   (transfer_en),
    .r_seg_en      (r_seg_en),
    .r_seg_len     (r_seg_len),
    .r_gap_cycles  (r_gap_cycles),
    .r_oneshot     (r_oneshot),
    .start         (start),
    .sr_loadout    (sr_loadout),
    .sr_shift_en   (sr_shift_en),
    .frame_done    (frame_done),
    .frame_cnt     (frame_cnt),
    .busy          (busy),
    .cfg_err       (cfg_err),
    .sr_sm_testbus (sr_sm_testbus)
  );

  assign obs = {sr_loadout, sr_shift_en, frame_done, busy, cfg_err, frame_cnt, sr_sm_testbus};

  // Expected observation vector built from individual expected fields
  function automatic logic [28:0] exp_vec(input bit ld, input bit sh, input bit fd, input bit bz,
                                          input bit cfg, input int fc, input int st, input int cnt);
    logic [7:0] fc8;
    logic [7:0] c8;
    logic [1:0] s2;
    fc8 = 8'(fc);
    c8  = 8'(cnt);
    s2  = 2'(st);
    return {ld, sh, fd, bz, cfg, fc8, 2'b00, s2, cfg, fd, sh, ld, c8};
  endfunction

  // Total chain length: sum of the enabled segment lengths
  function automatic int model_len(input logic [NUM_SEG-1:0] en,
                                   input logic [NUM_SEG*SEG_LEN_W-1:0] lens);
    int s;
    s = 0;
    for (int i = 0; i < NUM_SEG; i++) begin
      if (en[i]) s += int'(lens[i*SEG_LEN_W +: SEG_LEN_W]);
    end
    return s;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst         = 1'b1;
    transfer_en = 1'b0;
    start       = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [28:0] e;
    r_seg_en     = '0;
    r_seg_len    = '0;
    r_gap_cycles = '0;
    r_oneshot    = 1'b0;
    do_reset();
    e = exp_vec(1, 0, 0, 0, 0, 0, 0, 0);
    n_checks++;
    if (obs !== e) begin
      n_err++;
      $display("FAIL reset_values obs=%h exp=%h", obs, e);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (obs !== e) begin
      n_err++;
      $display("FAIL idle_no_enable obs=%h exp=%h", obs, e);
    end
  endtask

  // Continuous mode: frame period P = 1 + L + G after the first request
  task automatic test_continuous(input logic [NUM_SEG-1:0] en,
                                 input logic [NUM_SEG*SEG_LEN_W-1:0] lens,
                                 input logic [GAP_W-1:0] gap, input int nframes,
                                 input string name);
    int L, G, P, ph, fc, st, cnt;
    bit fd;
    logic [28:0] e;
    L = model_len(en, lens);
    G = int'(gap);
    P = 1 + L + G;
    fc = 0;
    do_reset();
    r_seg_en     = en;
    r_seg_len    = lens;
    r_gap_cycles = gap;
    r_oneshot    = 1'b0;
    transfer_en  = 1'b1;
    for (int k = 1; k <= nframes * P + 1; k++) begin
      @(negedge clk);
      ph  = (k - 1) % P;
      st  = (ph == 0) ? 1 : ((ph <= L) ? 2 : 3);
      cnt = (ph == 0) ? 0 : ((ph <= L) ? ph - 1 : ph - L - 1);
      fd  = (k >= L + 2) && (((k - L - 2) % P) == 0);
      fc  = (k >= L + 2) ? ((k - L - 2) / P + 1) : 0;
      e   = exp_vec(st == 1, st == 2, fd, 1, 0, fc, st, cnt);
      n_checks++;
      if (obs !== e) begin
        n_err++;
        $display("FAIL %s L=%0d G=%0d k=%0d obs=%h exp=%h", name, L, G, k, obs, e);
      end
    end
    transfer_en = 1'b0;
    @(negedge clk);
    e = exp_vec(1, 0, 0, 0, 0, fc, 0, 0);
    n_checks++;
    if (obs !== e) begin
      n_err++;
      $display("FAIL %s_disable obs=%h exp=%h", name, obs, e);
    end
  endtask

  task automatic test_oneshot();
    logic [28:0] e;
    int st;
    do_reset();
    r_seg_en     = 4'b0001;
    r_seg_len    = {21'd0, 7'd4};
    r_gap_cycles = '0;
    r_oneshot    = 1'b1;
    transfer_en  = 1'b1;
    repeat (2) begin
      @(negedge clk);
      e = exp_vec(1, 0, 0, 0, 0, 0, 0, 0);
      n_checks++;
      if (obs !== e) begin
        n_err++;
        $display("FAIL oneshot_wait obs=%h exp=%h", obs, e);
      end
    end
    start = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      start = (k == 3);
      st = (k == 1) ? 1 : ((k <= 5) ? 2 : 0);
      e  = exp_vec(st != 2, st == 2, k == 6, st != 0, 0, (k >= 6) ? 1 : 0, st,
                   (st == 2) ? k - 2 : 0);
      n_checks++;
      if (obs !== e) begin
        n_err++;
        $display("FAIL oneshot_frame k=%0d obs=%h exp=%h", k, obs, e);
      end
    end
    for (int i = 2; i <= 256; i++) begin
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      n_checks++;
      if ({frame_done, frame_cnt} !== {1'b1, 8'(i)}) begin
        n_err++;
        $display("FAIL oneshot_count frame=%0d got done=%b cnt=%0d want done=1 cnt=%0d",
                 i, frame_done, frame_cnt, i % 256);
      end
    end
    transfer_en = 1'b0;
    @(negedge clk);
    transfer_en = 1'b1;
    start       = 1'b1;
    @(negedge clk);
    start = 1'b0;
    e = exp_vec(1, 0, 0, 1, 0, 0, 1, 0);
    n_checks++;
    if (obs !== e) begin
      n_err++;
      $display("FAIL start_with_enable_edge obs=%h exp=%h", obs, e);
    end
    transfer_en = 1'b0;
    r_oneshot   = 1'b0;
  endtask

  task automatic test_zero_len();
    logic [28:0] e;
    int st;
    do_reset();
    r_seg_en     = '0;
    r_seg_len    = {7'd9, 7'd9, 7'd9, 7'd9};
    r_gap_cycles = '0;
    r_oneshot    = 1'b0;
    transfer_en  = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      e = exp_vec(1, 0, 0, 0, 1, 0, 0, 0);
      n_checks++;
      if (obs !== e) begin
        n_err++;
        $display("FAIL zero_len k=%0d obs=%h exp=%h", k, obs, e);
      end
    end
    r_seg_en  = 4'b0001;
    r_seg_len = {21'd0, 7'd7};
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      st = (k == 1 || k == 9) ? 1 : 2;
      e  = exp_vec(st == 1, st == 2, k == 9, 1, 0, (k == 9) ? 1 : 0, st,
                   (st == 2) ? k - 2 : 0);
      n_checks++;
      if (obs !== e) begin
        n_err++;
        $display("FAIL zero_len_recover k=%0d obs=%h exp=%h", k, obs, e);
      end
    end
    transfer_en = 1'b0;
  endtask

  task automatic test_abort();
    logic [28:0] e;
    int st;
    do_reset();
    r_seg_en     = 4'b0011;
    r_seg_len    = {7'd0, 7'd0, 7'd16, 7'd16};
    r_gap_cycles = '0;
    r_oneshot    = 1'b0;
    transfer_en  = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      st = (k == 1) ? 1 : 2;
      e  = exp_vec(st == 1, st == 2, 0, 1, 0, 0, st, (st == 2) ? k - 2 : 0);
      n_checks++;
      if (obs !== e) begin
        n_err++;
        $display("FAIL abort_pre k=%0d obs=%h exp=%h", k, obs, e);
      end
    end
    transfer_en = 1'b0;
    for (int j = 1; j <= 4; j++) begin
      @(negedge clk);
      e = exp_vec(1, 0, 0, 0, 0, 0, 0, 0);
      n_checks++;
      if (obs !== e) begin
        n_err++;
        $display("FAIL abort_idle j=%0d obs=%h exp=%h", j, obs, e);
      end
    end
    transfer_en = 1'b1;
    for (int k = 1; k <= 34; k++) begin
      @(negedge clk);
      st = (k == 1 || k == 34) ? 1 : 2;
      e  = exp_vec(st == 1, st == 2, k == 34, 1, 0, (k == 34) ? 1 : 0, st,
                   (st == 2) ? k - 2 : 0);
      n_checks++;
      if (obs !== e) begin
        n_err++;
        $display("FAIL abort_restart k=%0d obs=%h exp=%h", k, obs, e);
      end
    end
    transfer_en = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [28:0] e;
    logic [28:0] e_rst;
    e_rst = exp_vec(1, 0, 0, 0, 0, 0, 0, 0);
    do_reset();
    r_seg_en     = 4'b0001;
    r_seg_len    = {21'd0, 7'd5};
    r_gap_cycles = 3'd3;
    r_oneshot    = 1'b0;
    transfer_en  = 1'b1;
    repeat (8) @(negedge clk);
    e = exp_vec(0, 0, 0, 1, 0, 1, 3, 1);
    n_checks++;
    if (obs !== e) begin
      n_err++;
      $display("FAIL mid_gap_state obs=%h exp=%h", obs, e);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (obs !== e_rst) begin
      n_err++;
      $display("FAIL reset_mid_gap obs=%h exp=%h", obs, e_rst);
    end
    repeat (3) @(negedge clk);
    e = exp_vec(0, 1, 0, 1, 0, 0, 2, 1);
    n_checks++;
    if (obs !== e) begin
      n_err++;
      $display("FAIL mid_shift_state obs=%h exp=%h", obs, e);
    end
    rst = 1'b1;
    @(negedge clk);
    rst         = 1'b0;
    transfer_en = 1'b0;
    n_checks++;
    if (obs !== e_rst) begin
      n_err++;
      $display("FAIL reset_mid_shift obs=%h exp=%h", obs, e_rst);
    end
  endtask

  task automatic test_random();
    logic [NUM_SEG-1:0]           en;
    logic [NUM_SEG*SEG_LEN_W-1:0] lens;
    logic [GAP_W-1:0]             gap;
    for (int it = 0; it < 6; it++) begin
      en = NUM_SEG'($urandom_range(1, 15));
      for (int i = 0; i < NUM_SEG; i++) begin
        lens[i*SEG_LEN_W +: SEG_LEN_W] = SEG_LEN_W'($urandom_range(0, 24));
      end
      if (model_len(en, lens) == 0) begin
        en[0]                = 1'b1;
        lens[SEG_LEN_W-1:0] = 7'd3;
      end
      gap = GAP_W'($urandom_range(0, 7));
      test_continuous(en, lens, gap, 3, "random");
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst          = 1'b1;
    transfer_en  = 1'b0;
    start        = 1'b0;
    r_oneshot    = 1'b0;
    r_seg_en     = '0;
    r_seg_len    = '0;
    r_gap_cycles = '0;
    test_reset();
    test_continuous(4'b0011, {7'd0, 7'd0, 7'd16, 7'd16}, 3'd0, 3, "cont_16_16");
    test_continuous(4'b0001, {7'd0, 7'd0, 7'd0, 7'd5}, 3'd3, 4, "gap_5_3");
    test_continuous(4'b0100, {7'd0, 7'd1, 7'd0, 7'd0}, 3'd0, 4, "len_one");
    test_continuous(4'b1111, {7'd127, 7'd127, 7'd127, 7'd127}, 3'd7, 1, "len_max");
    test_oneshot();
    test_zero_len();
    test_abort();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
